funct_issue_unit: RTL and testbench



---
 rtl/funct_issue_pkg.sv | 52 +++++
 rtl/funct_issue_unit_map.sv | 45 ++++
 rtl/funct_issue_unit.sv | 178 +++++++++++++++++
 tb/tb_funct_issue_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/funct_issue_pkg.sv
// Shared constants for the funct issue path.
// Holds the opcode values recognised by the decode lanes, the ALU funct codes
// they produce, and the MDU / HI-LO funct codes used for hazard tracking.
package funct_issue_pkg;

    // Opcodes
    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_REGIMM   = 6'h01;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_BLEZ     = 6'h06;
    localparam logic [5:0] OP_BGTZ     = 6'h07;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LB       = 6'h20;
    localparam logic [5:0] OP_LH       = 6'h21;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_LBU      = 6'h24;
    localparam logic [5:0] OP_LHU      = 6'h25;
    localparam logic [5:0] OP_SB       = 6'h28;
    localparam logic [5:0] OP_SW       = 6'h2B;

    // ALU funct codes
    localparam logic [5:0] FUNCT_NOP   = 6'h00;
    localparam logic [5:0] FUNCT_ADDU  = 6'h21;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_XOR   = 6'h26;

    // HI/LO access and MDU funct codes
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    // True for the divide flavours, which use the long latency.
    function automatic logic is_div_funct(input logic [5:0] funct);
        return (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/funct_issue_unit_map.sv
// Combinational (op, funct) -> ALU funct mapping plus MDU / HI-LO classification.
// Reusable by any decode lane.
// Ports:
//   op_i       opcode
//   funct_i    instruction funct field
//   funct_o    ALU funct code
//   is_mdu_o   MULT/MULTU/DIV/DIVU
//   is_hilo_o  MFHI/MTHI/MFLO/MTLO
module funct_map
    import funct_issue_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6
) (
    input  logic [OP_W-1:0]    op_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output logic [FUNCT_W-1:0] funct_o,
    output logic               is_mdu_o,
    output logic               is_hilo_o
);

    always_comb begin
        funct_o = FUNCT_W'(FUNCT_NOP);
        case (op_i)
            OP_SPECIAL, OP_SPECIAL2:           funct_o = funct_i;
            OP_LUI, OP_ORI:                    funct_o = FUNCT_W'(FUNCT_OR);
            OP_XORI:                           funct_o = FUNCT_W'(FUNCT_XOR);
            OP_ANDI:                           funct_o = FUNCT_W'(FUNCT_AND);
            OP_SB, OP_SW, OP_ADDI, OP_ADDIU,
            OP_LB, OP_LBU, OP_LH, OP_LHU,
            OP_LW:                             funct_o = FUNCT_W'(FUNCT_ADDU);
            OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_BGTZ, OP_BLEZ, OP_REGIMM:       funct_o = FUNCT_W'(FUNCT_OR);
            default:                           funct_o = FUNCT_W'(FUNCT_NOP);
        endcase
    end

    always_comb begin
        is_mdu_o  = (op_i == OP_SPECIAL) &&
                    (funct_i inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU});
        is_hilo_o = (op_i == OP_SPECIAL) &&
                    (funct_i inside {FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO});
    end

endmodule

// File: rtl/funct_issue_unit.sv
// Registered, handshaked funct issue stage between ID decode and the ID/EX boundary.
// Maps (op, funct) to the ALU funct, presents it through a valid/ready output
// register, and tracks in-flight MDU ops with a latency counter so that later
// MDU or HI/LO instructions stall until the MDU drains.
// Optional: define FUNCT_ISSUE_SKID_EN to add one skid entry behind the output
// register, which decouples in_ready from out_ready.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   flush                  kill input and all buffered entries
//   in_valid/in_ready      decode-side handshake; in_op, in_funct
//   out_valid/out_ready    EX-side handshake; out_funct, out_is_mdu
//   mdu_busy               latency counter nonzero
//   mdu_done               one-cycle pulse on the first cycle the counter is 0
module funct_issue_unit
    import funct_issue_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic [FUNCT_W-1:0] in_funct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FUNCT_W-1:0] out_funct,
    output logic               out_is_mdu,
    output logic               mdu_busy,
    output logic               mdu_done
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [FUNCT_W-1:0] map_funct;
    logic               map_is_mdu;
    logic               map_is_hilo;

    funct_map #(
        .OP_W    (OP_W),
        .FUNCT_W (FUNCT_W)
    ) u_map (
        .op_i      (in_op),
        .funct_i   (in_funct),
        .funct_o   (map_funct),
        .is_mdu_o  (map_is_mdu),
        .is_hilo_o (map_is_hilo)
    );

    logic               out_valid_q, out_valid_d;
    logic [FUNCT_W-1:0] out_funct_q, out_funct_d;
    logic               out_is_mdu_q, out_is_mdu_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    logic hazard;
    logic accept;
    logic out_hs;
    logic mdu_pending;

    assign out_hs = out_valid_q && out_ready;

`ifdef FUNCT_ISSUE_SKID_EN
    logic               skid_valid_q, skid_valid_d;
    logic [FUNCT_W-1:0] skid_funct_q, skid_funct_d;
    logic               skid_is_mdu_q, skid_is_mdu_d;

    assign mdu_pending = (cnt_q != '0) || (out_valid_q && out_is_mdu_q) ||
                         (skid_valid_q && skid_is_mdu_q);
    assign hazard      = (map_is_mdu || map_is_hilo) && mdu_pending;
    assign in_ready    = !flush && !hazard && !skid_valid_q;
    assign accept      = in_valid && in_ready;

    always_comb begin
        out_valid_d   = out_valid_q;
        out_funct_d   = out_funct_q;
        out_is_mdu_d  = out_is_mdu_q;
        skid_valid_d  = skid_valid_q;
        skid_funct_d  = skid_funct_q;
        skid_is_mdu_d = skid_is_mdu_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // Output slot frees up: the older skid word goes first. A full skid
            // blocks in_ready, so accept cannot coincide with a skid move.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_funct_d  = skid_funct_q;
                out_is_mdu_d = skid_is_mdu_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d  = 1'b1;
                out_funct_d  = map_funct;
                out_is_mdu_d = map_is_mdu;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d  = 1'b1;
            skid_funct_d  = map_funct;
            skid_is_mdu_d = map_is_mdu;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_q  <= 1'b0;
            skid_funct_q  <= FUNCT_W'(FUNCT_NOP);
            skid_is_mdu_q <= 1'b0;
        end else begin
            skid_valid_q  <= skid_valid_d;
            skid_funct_q  <= skid_funct_d;
            skid_is_mdu_q <= skid_is_mdu_d;
        end
    end
`else
    assign mdu_pending = (cnt_q != '0) || (out_valid_q && out_is_mdu_q);
    assign hazard      = (map_is_mdu || map_is_hilo) && mdu_pending;
    assign in_ready    = !flush && !hazard && (!out_valid_q || out_ready);
    assign accept      = in_valid && in_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_funct_d  = out_funct_q;
        out_is_mdu_d = out_is_mdu_q;
        if (flush) begin
            out_valid_d  = 1'b0;
        end else if (accept) begin
            out_valid_d  = 1'b1;
            out_funct_d  = map_funct;
            out_is_mdu_d = map_is_mdu;
        end else if (out_hs) begin
            out_valid_d  = 1'b0;
        end
    end
`endif

    // The counter starts only on an EX handshake, so a flushed op that never
    // handshook never starts it, while a handshake in the flush cycle still does.
    always_comb begin
        cnt_d = cnt_q;
        if (out_hs && out_is_mdu_q) begin
            cnt_d = is_div_funct(6'(out_funct_q)) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        done_d = (cnt_q == CNT_W'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_funct_q  <= FUNCT_W'(FUNCT_NOP);
            out_is_mdu_q <= 1'b0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_funct_q  <= out_funct_d;
            out_is_mdu_q <= out_is_mdu_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_funct  = out_funct_q;
    assign out_is_mdu = out_is_mdu_q;
    assign mdu_busy   = (cnt_q != '0);
    assign mdu_done   = done_q;

endmodule

// File: tb/tb_funct_issue_unit.sv
// Self-checking bench for funct_issue_unit (default build; the stalled-input
// in_ready check is skipped when FUNCT_ISSUE_SKID_EN is defined).
// Issued words are pushed to a scoreboard with their expected funct/is_mdu and
// compared when EX handshakes them; directed checks cover MDU hazards, stalls,
// flush and asynchronous reset.
module tb_funct_issue_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_op;
    logic [5:0] in_funct;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_funct;
    logic       out_is_mdu;
    logic       mdu_busy;
    logic       mdu_done;

    int total = 0;
    int bad   = 0;
    logic [6:0] sb[$];

    always #5 clk = ~clk;

    funct_issue_unit #(
        .OP_W    (6),
        .FUNCT_W (6),
        .MUL_LAT (4),
        .DIV_LAT (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_funct   (in_funct),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_funct  (out_funct),
        .out_is_mdu (out_is_mdu),
        .mdu_busy   (mdu_busy),
        .mdu_done   (mdu_done)
    );

    // Reference mapping: returns {is_mdu, funct}.
    function automatic logic [6:0] exp_map(input logic [5:0] op, input logic [5:0] fn);
        logic [5:0] f;
        logic       m;
        m = (op == 6'h00) && (fn >= 6'h18) && (fn <= 6'h1B);
        case (op)
            6'h00, 6'h1C:                             f = fn;
            6'h0F, 6'h0D:                             f = 6'h25;
            6'h0E:                                    f = 6'h26;
            6'h0C:                                    f = 6'h24;
            6'h28, 6'h2B, 6'h08, 6'h09, 6'h20,
            6'h24, 6'h21, 6'h25, 6'h23:               f = 6'h21;
            6'h02, 6'h03, 6'h04, 6'h05, 6'h07,
            6'h06, 6'h01:                             f = 6'h25;
            default:                                  f = 6'h00;
        endcase
        return {m, f};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    // Called between negedge and posedge: record handshakes, then advance.
    task automatic sample_edge();
        logic [6:0] e;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("sb_funct", out_funct, e[5:0]);
                chk("sb_is_mdu", out_is_mdu, e[6]);
            end
        end
        if (flush) sb.delete();
        else if (in_valid && in_ready) sb.push_back(exp_map(in_op, in_funct));
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        to_neg();
        sample_edge();
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn);
        in_valid = v;
        in_op    = op;
        in_funct = fn;
    endtask

    // Counts cycles with mdu_busy high; returns at the negedge where it is low.
    task automatic wait_busy(output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            to_neg();
            if (!mdu_busy) return;
            n++;
            sample_edge();
        end
        to_neg();
    endtask

    logic [5:0] tbl_op [6];
    logic [5:0] tbl_fn [6];

    initial begin
        int n;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 6'h00, 6'h00);
        tbl_op = '{6'h23, 6'h04, 6'h0F, 6'h3F, 6'h1C, 6'h28};
        tbl_fn = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h00};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_funct", out_funct, 6'h00);
        chk("rst_out_is_mdu", out_is_mdu, 0);
        chk("rst_mdu_busy", mdu_busy, 0);
        chk("rst_mdu_done", mdu_done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ORI then back-to-back ADDIU, XORI
        out_ready = 1'b1;
        drive(1'b1, 6'h0D, 6'h00);
        to_neg(); chk("ori_in_ready", in_ready, 1); sample_edge();
        drive(1'b1, 6'h09, 6'h00);
        to_neg(); chk("ori_out_valid", out_valid, 1); chk("ori_out_funct", out_funct, 6'h25);
        sample_edge();
        drive(1'b1, 6'h0E, 6'h00);
        to_neg(); chk("addiu_out_funct", out_funct, 6'h21); sample_edge();
        drive(1'b0, 6'h00, 6'h00);
        to_neg(); chk("xori_out_funct", out_funct, 6'h26); sample_edge();
        to_neg(); chk("drain_out_valid", out_valid, 0); sample_edge();

        // Mapping sweep through the scoreboard
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, tbl_op[i], tbl_fn[i]);
            to_neg(); chk("sweep_in_ready", in_ready, 1); sample_edge();
        end
        drive(1'b0, 6'h00, 6'h00);
        cycle();
        cycle();

        // MULT then MFLO: stalled while MULT presented and for MUL_LAT cycles
        drive(1'b1, 6'h00, 6'h18);
        to_neg(); chk("mult_in_ready", in_ready, 1); sample_edge();
        drive(1'b1, 6'h00, 6'h12);
        to_neg(); chk("mult_out_is_mdu", out_is_mdu, 1); chk("mflo_stall_pres", in_ready, 0);
        sample_edge();
        for (int i = 0; i < 4; i++) begin
            to_neg();
            chk("mul_busy", mdu_busy, 1);
            chk("mflo_stall", in_ready, 0);
            chk("mul_done_early", mdu_done, 0);
            sample_edge();
        end
        to_neg();
        chk("mul_busy_end", mdu_busy, 0);
        chk("mul_done", mdu_done, 1);
        chk("mflo_accept", in_ready, 1);
        sample_edge();
        drive(1'b0, 6'h00, 6'h00);
        to_neg(); chk("mul_done_pulse", mdu_done, 0); chk("mflo_out_funct", out_funct, 6'h12);
        sample_edge();
        cycle();

        // DIV then ADDU: ADDU not stalled, busy for DIV_LAT cycles
        drive(1'b1, 6'h00, 6'h1A);
        to_neg(); chk("div_in_ready", in_ready, 1); sample_edge();
        drive(1'b1, 6'h00, 6'h21);
        to_neg(); chk("addu_no_stall", in_ready, 1); sample_edge();
        drive(1'b0, 6'h00, 6'h00);
        wait_busy(n);
        chk("div_busy_cycles", n, 32);
        chk("div_done", mdu_done, 1);
        sample_edge();
        cycle();

        // ANDI held with out_ready low for 3 cycles
        out_ready = 1'b0;
        drive(1'b1, 6'h0C, 6'h00);
        to_neg(); chk("andi_in_ready", in_ready, 1); sample_edge();
        for (int i = 0; i < 3; i++) begin
            to_neg();
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_funct", out_funct, 6'h24);
`ifndef FUNCT_ISSUE_SKID_EN
            chk("stall_in_ready", in_ready, 0);
`endif
            sample_edge();
        end
        drive(1'b0, 6'h00, 6'h00);
        out_ready = 1'b1;
        repeat (3) cycle();

        // DIVU in the output register, flushed before EX takes it
        out_ready = 1'b0;
        drive(1'b1, 6'h00, 6'h1B);
        cycle();
        drive(1'b0, 6'h00, 6'h00);
        flush = 1'b1;
        to_neg(); chk("divu_out_valid", out_valid, 1); chk("flush_in_ready", in_ready, 0);
        sample_edge();
        flush = 1'b0;
        out_ready = 1'b1;
        to_neg(); chk("flush_out_valid", out_valid, 0); chk("flush_no_count", mdu_busy, 0);
        sample_edge();
        to_neg(); chk("flush_no_count2", mdu_busy, 0); sample_edge();

        // Flush during a MULT count: count still runs to mdu_done
        drive(1'b1, 6'h00, 6'h18);
        cycle();
        drive(1'b0, 6'h00, 6'h00);
        cycle();
        flush = 1'b1;
        to_neg(); chk("flush_mul_busy", mdu_busy, 1); sample_edge();
        flush = 1'b0;
        wait_busy(n);
        chk("flush_mul_rest", n, 3);
        chk("flush_mul_done", mdu_done, 1);
        sample_edge();
        cycle();

        // Reset mid-DIV (counter 17) with ORI held in the output register
        drive(1'b1, 6'h00, 6'h1A);
        cycle();
        drive(1'b0, 6'h00, 6'h00);
        cycle();
        out_ready = 1'b0;
        drive(1'b1, 6'h0D, 6'h00);
        cycle();
        drive(1'b0, 6'h00, 6'h00);
        repeat (14) cycle();
        to_neg();
        chk("pre_rst_busy", mdu_busy, 1);
        chk("pre_rst_out_funct", out_funct, 6'h25);
        rst = 1'b1;
        #1;
        chk("arst_busy", mdu_busy, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_funct", out_funct, 6'h00);
        chk("arst_done", mdu_done, 0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        to_neg(); chk("post_rst_busy", mdu_busy, 0); sample_edge();
        chk("sb_drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
